// File: rtl/wb_spi_flash.sv
// Read-only Wishbone B4 classic slave that fetches 32-bit words from an SPI NOR flash (mode 0).
// Optional macro WB_SPI_FLASH_FAST_READ_EN selects FAST READ (0x0B) with 8 dummy clocks.
module wb_spi_flash #(
  parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
  parameter logic [31:0] SIZE         = 32'h0100_0000,
  parameter int unsigned CLK_DIV      = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic        spi_sck_o,
  output logic        spi_cs_n_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DUMMY, S_DATA, S_ACK, S_ERR} state_t;

`ifdef WB_SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam state_t     AFTER_CMD = S_DUMMY;
`else
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam state_t     AFTER_CMD = S_DATA;
`endif

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic             sck_q, cs_n_q, mosi_q;
  logic [31:0]      tx_sh, rx_sh;
  logic [31:0]      off;
  logic             hit, start, shifting, abort, tick, rise, fall, phase_last;
  logic             unused_ok;

  // Flash bytes arrive in address order; byte 0 lands in the least significant lane.
  function automatic logic [31:0] le_word(input logic [31:0] s);
    return {s[7:0], s[15:8], s[23:16], s[31:24]};
  endfunction

  assign off        = adr_i - BASE_ADDRESS;
  assign hit        = cyc_i & stb_i & (adr_i >= BASE_ADDRESS) & (off < SIZE);
  assign start      = (state == S_IDLE) & hit & ~we_i;
  assign shifting   = (state == S_CMD) | (state == S_DUMMY) | (state == S_DATA);
  assign abort      = shifting & ~cyc_i;
  assign tick       = shifting & (div_cnt == DIV_LAST);
  assign rise       = tick & ~sck_q;
  assign fall       = tick & sck_q;
  assign phase_last = (state == S_DUMMY) ? (bit_cnt == 5'd7) : (bit_cnt == 5'd31);
  assign unused_ok  = ^{sel_i, dat_i, off[31:24], off[1:0]};

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (hit) state_nxt = we_i ? S_ERR : S_CMD;
      S_CMD:   if (abort) state_nxt = S_IDLE;
               else if (fall && phase_last) state_nxt = AFTER_CMD;
      S_DUMMY: if (abort) state_nxt = S_IDLE;
               else if (fall && phase_last) state_nxt = S_DATA;
      S_DATA:  if (abort) state_nxt = S_IDLE;
               else if (fall && phase_last) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        cs_n_q  <= 1'b0;
        sck_q   <= 1'b0;
        mosi_q  <= CMD_READ[7];
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (abort) begin
        cs_n_q <= 1'b1;
        sck_q  <= 1'b0;
        mosi_q <= 1'b0;
      end else if (shifting) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) sck_q <= ~sck_q;
        // Falling SCK closes a bit: MOSI moves on while SCK is low again.
        if (fall) begin
          bit_cnt <= phase_last ? 5'd0 : bit_cnt + 5'd1;
          mosi_q  <= (state_nxt == S_CMD) ? tx_sh[31] : 1'b0;
          if (state_nxt == S_ACK) cs_n_q <= 1'b1;
        end
      end
    end
  end

  // Shift registers carry data only and need no reset.
  always_ff @(posedge clk_i) begin
    if (start) tx_sh <= {CMD_READ[6:0], off[23:2], 2'b00, 1'b0};
    else if (fall) tx_sh <= {tx_sh[30:0], 1'b0};
    if (rise && state == S_DATA) rx_sh <= {rx_sh[30:0], spi_miso_i};
  end

  assign ack_o      = (state == S_ACK);
  assign err_o      = (state == S_ERR);
  assign dat_o      = ack_o ? le_word(rx_sh) : 32'h0;
  assign rty_o      = 1'b0;
  assign spi_sck_o  = sck_q;
  assign spi_cs_n_o = cs_n_q;
  assign spi_mosi_o = mosi_q;

endmodule

// File: tb/tb_wb_spi_flash.sv
// Bench for wb_spi_flash: behavioural SPI flash, table-driven reads and a scoreboard of responses.
`timescale 1ns/1ps
module tb_wb_spi_flash;

  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef WB_SPI_FLASH_FAST_READ_EN
  localparam int         HDR    = 40;
  localparam logic [7:0] RD_CMD = 8'h0B;
`else
  localparam int         HDR    = 32;
  localparam logic [7:0] RD_CMD = 8'h03;
`endif
  localparam int DIV1 = 3;
  localparam int LAT0 = 2 * (HDR + 32);
  localparam int LAT1 = 2 * (HDR + 32) * DIV1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cyc;
  logic        stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic [31:0] dat_o [2];
  logic [1:0]  ack, err, rty, sck, cs_n, mosi;
  logic [1:0]  miso = 2'b00;
  longint      cnt = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  wb_spi_flash #(.BASE_ADDRESS(BASE), .SIZE(32'h0100_0000), .CLK_DIV(1)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .stb_i(stb), .cyc_i(cyc[0]), .adr_i(adr), .sel_i(sel),
    .we_i(we), .dat_i(wdat), .dat_o(dat_o[0]), .ack_o(ack[0]), .err_o(err[0]), .rty_o(rty[0]),
    .spi_sck_o(sck[0]), .spi_cs_n_o(cs_n[0]), .spi_mosi_o(mosi[0]), .spi_miso_i(miso[0]));

  wb_spi_flash #(.BASE_ADDRESS(BASE), .SIZE(32'h0100_0000), .CLK_DIV(DIV1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .stb_i(stb), .cyc_i(cyc[1]), .adr_i(adr), .sel_i(sel),
    .we_i(we), .dat_i(wdat), .dat_o(dat_o[1]), .ack_o(ack[1]), .err_o(err[1]), .rty_o(rty[1]),
    .spi_sck_o(sck[1]), .spi_cs_n_o(cs_n[1]), .spi_mosi_o(mosi[1]), .spi_miso_i(miso[1]));

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h93;
      24'h000101: return 8'h00;
      24'h000102: return 8'h50;
      24'h000103: return 8'h00;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  // Flash model and bus-rule monitors, evaluated on the falling clock edge.
  int          rcnt [2]       = '{0, 0};
  int          rises_last [2] = '{0, 0};
  int          cs_low_cnt [2] = '{0, 0};
  int          hi_run [2]     = '{0, 0};
  logic [31:0] cmd_sh [2];
  logic [31:0] cmd_cap [2];
  logic [1:0]  sck_prev = 2'b00, cs_prev = 2'b11, dummy_or = 2'b00, seen_low = 2'b00;
  int          dat_viol = 0, sck_viol = 0, gap_viol = 0;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      logic [7:0] fb;
      int b;
      if (cs_n[g] === 1'b1) begin
        if (cs_prev[g] === 1'b0) rises_last[g] = rcnt[g];
        rcnt[g] = 0;
        miso[g] = 1'b0;
        hi_run[g] = hi_run[g] + 1;
        if (sck[g] === 1'b1) sck_viol++;
      end else if (cs_n[g] === 1'b0) begin
        if (cs_prev[g] === 1'b1) begin
          dummy_or[g] = 1'b0;
          if (seen_low[g] && hi_run[g] < 2) gap_viol++;
        end
        seen_low[g] = 1'b1;
        hi_run[g] = 0;
        cs_low_cnt[g] = cs_low_cnt[g] + 1;
        if (sck[g] === 1'b1 && sck_prev[g] === 1'b0) begin
          if (rcnt[g] < 32) cmd_sh[g] = {cmd_sh[g][30:0], mosi[g]};
          else if (rcnt[g] < HDR) dummy_or[g] = dummy_or[g] | mosi[g];
          rcnt[g] = rcnt[g] + 1;
          if (rcnt[g] == 32) cmd_cap[g] = cmd_sh[g];
        end else if (sck[g] === 1'b0 && sck_prev[g] === 1'b1 && rcnt[g] >= HDR) begin
          b = rcnt[g] - HDR;
          fb = flash_byte(cmd_sh[g][23:0] + 24'(b / 8));
          miso[g] = fb[7 - (b % 8)];
        end
      end
      if (ack[g] === 1'b0 && dat_o[g] !== 32'h0) dat_viol++;
      cs_prev[g] = cs_n[g];
      sck_prev[g] = sck[g];
    end
  end

  typedef struct {
    int          inst;
    int          kind;
    logic [31:0] dat;
    logic [31:0] cmd;
    longint      cyc_at;
  } exp_t;
  exp_t sb [$];

  typedef struct {
    logic [31:0] adr;
    logic        we;
    int          kind;
    logic [31:0] dat;
    logic [23:0] fa;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic issue(input int g, input logic [31:0] a, input logic w);
    @(negedge clk); #1;
    adr = a; we = w; stb = 1'b1; cyc[g] = 1'b1;
  endtask

  task automatic release_bus();
    cyc = 2'b00; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wait_resp(input int g, input int budget);
    exp_t e;
    bit   got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk); #1;
      if (ack[g] || err[g]) begin
        got = 1;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp inst=%0d ack=%b err=%b", g, ack[g], err[g]);
        end else begin
          e = sb.pop_front();
          chk("resp_inst", g, e.inst);
          chk("resp_kind", ack[g] ? 1 : 2, e.kind);
          chk("resp_cycle", cnt, e.cyc_at);
          chk("dat_o", dat_o[g], (e.kind == 1) ? e.dat : 32'h0);
          if (e.kind == 1) begin
            chk("spi_cmd", cmd_cap[g], e.cmd);
            chk("sck_rises", rises_last[g], HDR + 32);
            chk("dummy_mosi", dummy_or[g], 0);
          end
        end
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL resp_timeout inst=%0d actual=none required=response", g);
      sb.delete();
    end
  endtask

  task automatic wait_quiet(input int g, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk); #1;
      if (ack[g] || err[g]) seen++;
    end
    chk("no_resp", seen, 0);
  endtask

  task automatic chk_idle_outputs(input string tag, input int g);
    chk({tag, "_cs_n"}, cs_n[g], 1);
    chk({tag, "_sck"}, sck[g], 0);
    chk({tag, "_mosi"}, mosi[g], 0);
    chk({tag, "_ack"}, ack[g], 0);
    chk({tag, "_err"}, err[g], 0);
    chk({tag, "_dat"}, dat_o[g], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vt [9];
    exp_t   e;
    longint c;
    int     low0;

    vt[0] = '{32'h1000_0100, 1'b0, 1, 32'h0050_0093, 24'h000100};
    vt[1] = '{32'h1000_0103, 1'b0, 1, 32'h0050_0093, 24'h000100};
    vt[2] = '{32'h1000_0000, 1'b1, 2, 32'h0, 24'h0};
    vt[3] = '{32'h2000_0000, 1'b0, 0, 32'h0, 24'h0};
    vt[4] = '{32'h10FF_FFFC, 1'b0, 1, 32'hA5A4_A7A6, 24'hFFFFFC};
    vt[5] = '{32'h1100_0000, 1'b0, 0, 32'h0, 24'h0};
    vt[6] = '{32'h0FFF_FFFC, 1'b0, 0, 32'h0, 24'h0};
    vt[7] = '{32'h1012_3458, 1'b0, 1, 32'h2726_2524, 24'h123458};
    vt[8] = '{32'h10FF_FFFF, 1'b1, 2, 32'h0, 24'h0};

    rst_n = 1'b1; cyc = 2'b00; stb = 1'b0; we = 1'b0;
    adr = 32'h0; wdat = 32'hDEAD_BEEF; sel = 4'hF;
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("reset0", 0);
    chk_idle_outputs("reset1", 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      low0 = cs_low_cnt[0];
      issue(0, vt[i].adr, vt[i].we);
      c = cnt;
      if (vt[i].kind != 0) begin
        e = '{0, vt[i].kind, vt[i].dat, {RD_CMD, vt[i].fa},
              c + 1 + ((vt[i].kind == 1) ? LAT0 : 0)};
        sb.push_back(e);
        wait_resp(0, LAT0 + 20);
      end else begin
        wait_quiet(0, 40);
      end
      release_bus();
      @(negedge clk); #1;
      chk("dat_after", dat_o[0], 0);
      chk("ack_after", ack[0], 0);
      if (vt[i].kind != 1) chk("no_spi_activity", cs_low_cnt[0] - low0, 0);
    end

    issue(0, 32'h1000_0100, 1'b0);
    c = cnt;
    repeat (40) @(negedge clk);
    #1 chk("abort_active_cs", cs_n[0], 0);
    release_bus();
    @(negedge clk); #1;
    chk("abort_cycle", cnt, c + 41);
    chk("abort_cs_n", cs_n[0], 1);
    chk("abort_sck", sck[0], 0);
    wait_quiet(0, LAT0 + 20);

    issue(0, 32'h1012_3458, 1'b0);
    repeat (100) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk_idle_outputs("reset_mid", 0);
    release_bus();
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 32'h1000_0100, 1'b0);
    c = cnt;
    sb.push_back('{0, 1, 32'h0050_0093, {RD_CMD, 24'h000100}, c + 1 + LAT0});
    wait_resp(0, LAT0 + 20);
    release_bus();

    issue(1, 32'h1000_0100, 1'b0);
    c = cnt;
    sb.push_back('{1, 1, 32'h0050_0093, {RD_CMD, 24'h000100}, c + 1 + LAT1});
    sb.push_back('{1, 1, 32'h2726_2524, {RD_CMD, 24'h123458}, c + 1 + LAT1 + 2 + LAT1});
    wait_resp(1, LAT1 + 20);
    adr = 32'h1012_3458;
    wait_resp(1, LAT1 + 20);
    release_bus();
    wait_quiet(1, 10);

    chk("scoreboard_empty", sb.size(), 0);
    chk("dat_o_outside_ack", dat_viol, 0);
    chk("sck_high_while_deselected", sck_viol, 0);
    chk("cs_gap_short", gap_viol, 0);
    chk("rty_o", rty, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
